// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
// The arbiter FSM walks StIdle -> StActive -> StRelease for every access.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StRelease
    } arb_state_t;

    localparam int unsigned DefAddrW = 18;
    localparam int unsigned DefDataW = 16;

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational round-robin search: the first set request at or after rr_ptr, wrapping
// around to port 0.
module sram_rr_picker #(
    parameter int unsigned NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
    output logic [$clog2(NUM_PORTS)-1:0] winner,
    output logic                         any
);

    localparam int unsigned PtrW = $clog2(NUM_PORTS);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        // Ports at or above the pointer win over the wrapped-around ones.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!any && req[i] && (i >= 32'(rr_ptr))) begin
                any    = 1'b1;
                winner = PtrW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                winner = PtrW'(i);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous-SRAM controller among NUM_PORTS requesters: round-robin grant,
// one access at a time, with read data, ack or timeout error returned to the winner.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 3,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [NUM_PORTS-1:0]         we,
    input  logic [NUM_PORTS*ADDR_W-1:0]  addr,
    input  logic [NUM_PORTS*DATA_W-1:0]  wdata,
    output logic [NUM_PORTS-1:0]         ack,
    output logic [NUM_PORTS-1:0]         err,
    output logic [DATA_W-1:0]            rdata,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         mem_rd_en,
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_rd_valid,
    input  logic                         mem_wr_valid,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_busy
);

    localparam int unsigned PtrW = $clog2(NUM_PORTS);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_PORTS - 1);

    arb_state_t            state;
    logic [PtrW-1:0]       rr_ptr;
    logic [PtrW-1:0]       winner;
    logic                  any;
    logic                  cur_we;
    logic                  done;
    logic [CntW-1:0]       cnt;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata;
    logic                  win_we;
    logic [NUM_PORTS-1:0]  grant_onehot;

    sram_rr_picker #(
        .NUM_PORTS(NUM_PORTS)
    ) u_picker (
        .req   (req),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any   (any)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (winner == PtrW'(k)) begin
                win_addr  = addr[k*ADDR_W +: ADDR_W];
                win_wdata = wdata[k*DATA_W +: DATA_W];
                win_we    = we[k];
            end
        end
    end

    assign grant_onehot = NUM_PORTS'(1) << grant_id;
    // Only the valid matching the issued direction completes the access.
    assign done = cur_we ? mem_wr_valid : mem_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            cnt       <= '0;
            cur_we    <= 1'b0;
            ack       <= '0;
            err       <= '0;
            rdata     <= '0;
            grant_id  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                StIdle: begin
                    if (any && !mem_busy) begin
                        grant_id  <= winner;
                        rr_ptr    <= (winner == PtrLast) ? '0 : winner + 1'b1;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        cur_we    <= win_we;
                        mem_rd_en <= !win_we;
                        mem_wr_en <= win_we;
                        cnt       <= '0;
                        state     <= StActive;
                    end
                end
                StActive: begin
                    if (cnt != CntMax) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (done) begin
                        if (!cur_we) begin
                            rdata <= mem_rdata;
                        end
                        ack       <= grant_onehot;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        state     <= StRelease;
                    end else if (cnt == CntLast) begin
                        err       <= grant_onehot;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        state     <= StRelease;
                    end
                end
                StRelease: begin
                    if (!mem_busy) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter with a behavioural SRAM controller.
// Service order is predicted per round from the round-robin rule over the requesting set.
module tb_sram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 64;
    localparam int NEVER = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     ack;
    logic [NP-1:0]     err;
    logic [DW-1:0]     rdata;
    logic [1:0]        grant_id;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rd_valid;
    logic              mem_wr_valid;
    logic [DW-1:0]     mem_rdata;
    logic              mem_busy;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NUM_PORTS     (NP),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .grant_id    (grant_id),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd_valid(mem_rd_valid),
        .mem_wr_valid(mem_wr_valid),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy)
    );

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            en_cycles;
    } cmd_t;

    typedef struct {
        int            port;
        bit            is_err;
        logic [DW-1:0] rd;
    } rsp_t;

    typedef struct {
        int            lat;
        logic [DW-1:0] rd;
    } beat_t;

    cmd_t  cmd_q[$];
    rsp_t  rsp_q[$];
    beat_t beat_q[$];

    int total = 0;
    int bad = 0;
    int ptr_m = 0;
    logic [DW-1:0] last_rd_m = '0;
    bit force_busy = 1'b0;
    bit aborted = 1'b0;

    logic          st_we[NP];
    logic [AW-1:0] st_addr[NP];
    logic [DW-1:0] st_wdata[NP];
    logic [DW-1:0] st_rd[NP];
    int            st_lat[NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stage(input int p, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat, input logic [DW-1:0] rd);
        st_we[p]    = w;
        st_addr[p]  = a;
        st_wdata[p] = d;
        st_lat[p]   = lat;
        st_rd[p]    = rd;
    endtask

    task automatic stage_random(input int p);
        int sel;
        int lat;
        sel = $urandom_range(0, 19);
        if (sel == 0)      lat = NEVER;
        else if (sel == 1) lat = TO;
        else if (sel == 2) lat = TO + 1;
        else               lat = $urandom_range(1, 15);
        stage(p, 1'($urandom), AW'($urandom), DW'($urandom), lat, DW'($urandom));
    endtask

    // Reference: with a fixed requesting set, service is a scan from the pointer, and
    // each grant moves the pointer just past the winner.
    task automatic launch(input bit [NP-1:0] mask);
        bit [NP-1:0] pend;
        int w;
        bit is_err;
        if (aborted) return;
        pend = mask;
        for (int n = 0; n < NP; n++) begin
            if (pend == '0) break;
            w = ptr_m;
            while (!pend[w]) w = (w + 1) % NP;
            is_err = st_lat[w] > TO;
            cmd_q.push_back('{w, st_we[w], st_addr[w], st_wdata[w], is_err ? TO : st_lat[w]});
            if (!is_err && !st_we[w]) last_rd_m = st_rd[w];
            rsp_q.push_back('{w, is_err, last_rd_m});
            beat_q.push_back('{st_lat[w], st_rd[w]});
            pend[w] = 1'b0;
            ptr_m = (w + 1) % NP;
        end
        @(negedge clk);
        for (int k = 0; k < NP; k++) begin
            we[k]              = st_we[k];
            addr[k*AW +: AW]   = st_addr[k];
            wdata[k*DW +: DW]  = st_wdata[k];
        end
        req = mask;
    endtask

    task automatic finish_round();
        if (aborted) return;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req = req & ~(ack | err);
            if (req == '0) break;
        end
        check("round_done", 64'(req), 64'(0));
        if (req != '0) begin
            aborted = 1'b1;
            req = '0;
        end
    endtask

    // Behavioural SRAM controller: valid in the lat-th enable cycle, a few busy tail
    // cycles afterwards, and occasional valid pulses of the wrong direction.
    initial begin : ctrl
        int cnt;
        int tail;
        beat_t b;
        cnt = 0;
        tail = 0;
        b = '{5, '0};
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
        mem_rdata    = '0;
        mem_busy     = 1'b0;
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_wr_valid = 1'b0;
            mem_rdata    = DW'($urandom);
            if (mem_rd_en || mem_wr_en) begin
                if (cnt == 0) begin
                    if (beat_q.size() == 0) b = '{5, '0};
                    else b = beat_q.pop_front();
                end
                cnt++;
                if (cnt == b.lat) begin
                    if (mem_wr_en) begin
                        mem_wr_valid = 1'b1;
                    end else begin
                        mem_rd_valid = 1'b1;
                        mem_rdata    = b.rd;
                    end
                    tail = $urandom_range(0, 3);
                end else if ($urandom_range(0, 7) == 0) begin
                    if (mem_wr_en) mem_rd_valid = 1'b1;
                    else           mem_wr_valid = 1'b1;
                end
                mem_busy = 1'b1;
            end else begin
                cnt = 0;
                mem_busy = force_busy || (tail > 0);
                if (tail > 0) tail--;
            end
        end
    end

    initial begin : monitor
        bit   prev_en;
        bit   en;
        int   en_len;
        cmd_t cur;
        rsp_t r;
        logic [NP-1:0] exp_ack;
        logic [NP-1:0] exp_err;
        prev_en = 1'b0;
        en_len = 0;
        cur = '{0, 1'b0, '0, '0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
                en_len = 0;
            end else begin
                en = mem_rd_en | mem_wr_en;
                if (en && !prev_en) begin
                    if (cmd_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_grant: grant_id=%0d, none expected", grant_id);
                        cur.en_cycles = 0;
                    end else begin
                        cur = cmd_q.pop_front();
                        check("grant_id", 64'(grant_id), 64'(cur.port));
                        check("mem_addr", 64'(mem_addr), 64'(cur.a));
                        check("mem_en_rd_wr", 64'({mem_rd_en, mem_wr_en}),
                              64'({!cur.wr, cur.wr}));
                        if (cur.wr) check("mem_wdata", 64'(mem_wdata), 64'(cur.d));
                    end
                    en_len = 1;
                end else if (en) begin
                    en_len++;
                end else if (prev_en) begin
                    check("enable_cycles", 64'(en_len), 64'(cur.en_cycles));
                end
                if (ack != '0 || err != '0) begin
                    if (rsp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: ack=%b err=%b, none expected", ack, err);
                    end else begin
                        r = rsp_q.pop_front();
                        exp_ack = r.is_err ? '0 : NP'(1) << r.port;
                        exp_err = r.is_err ? NP'(1) << r.port : '0;
                        check("ack", 64'(ack), 64'(exp_ack));
                        check("err", 64'(err), 64'(exp_err));
                        check("rdata", 64'(rdata), 64'(r.rd));
                    end
                end
                prev_en = en;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"}, 64'(ack), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_rdata"}, 64'(rdata), 64'(0));
        check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        check({tag, "_mem_en"}, 64'({mem_rd_en, mem_wr_en}), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    initial begin : driver
        int k;
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // All ports requesting from reset: strictly 0,1,2,0,1,2.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) stage(p, 1'b0, AW'(p + 16), '0, 4, DW'($urandom));
            launch(3'b111);
            finish_round();
        end

        stage(1, 1'b0, 18'h00ABC, '0, 12, 16'hBEEF);
        launch(3'b010);
        finish_round();

        stage(2, 1'b1, 18'h3FFFF, 16'h1234, 7, 16'h5555);
        launch(3'b100);
        finish_round();

        stage(0, 1'b0, 18'h00100, '0, NEVER, 16'h0);
        launch(3'b001);
        finish_round();
        stage(0, 1'b0, 18'h00101, '0, 3, 16'h7A7A);
        launch(3'b001);
        finish_round();

        // Timeout boundary: valid in the last allowed cycle wins, one later aborts.
        stage(1, 1'b0, 18'h00200, '0, TO - 1, 16'h1111);
        stage(2, 1'b0, 18'h00201, '0, TO, 16'h2222);
        stage(0, 1'b0, 18'h00202, '0, TO + 1, 16'h3333);
        launch(3'b111);
        finish_round();

        // mem_busy held in IDLE blocks the grant.
        force_busy = 1'b1;
        repeat (6) @(negedge clk);
        stage(1, 1'b0, 18'h01234, '0, 5, 16'hC0DE);
        launch(3'b010);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("busy_block", 64'({mem_rd_en, mem_wr_en}), 64'(0));
        end
        force_busy = 1'b0;
        finish_round();

        // Reset in the 5th ACTIVE cycle of a port-1 read.
        if (!aborted) begin
            repeat (6) @(negedge clk);
            cmd_q.push_back('{1, 1'b0, 18'h02222, '0, 0});
            beat_q.push_back('{NEVER, '0});
            @(negedge clk);
            we[1] = 1'b0;
            addr[1*AW +: AW] = 18'h02222;
            req = 3'b010;
            k = 0;
            for (int c = 0; c < 40 && k < 5; c++) begin
                @(negedge clk);
                if (mem_rd_en || mem_wr_en) k++;
            end
            check("rst_test_active_cycles", 64'(k), 64'(5));
            rst = 1'b1;
            @(negedge clk);
            check_outputs_zero("mid_rst");
            req = '0;
            rst = 1'b0;
            cmd_q.delete();
            rsp_q.delete();
            beat_q.delete();
            ptr_m = 0;
            last_rd_m = '0;
            for (int p = 0; p < NP; p++) stage_random(p);
            launch(3'b111);
            finish_round();
        end

        for (int r = 0; r < 60; r++) begin
            for (int p = 0; p < NP; p++) stage_random(p);
            launch(NP'($urandom_range(1, (1 << NP) - 1)));
            finish_round();
        end

        repeat (10) @(negedge clk);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
